// File: rtl/caxi4interconnect_dwc_aw_splitter.sv
// DWC write-address splitter: breaks one wide-master AW into narrow-slave AWs of at most 256 beats
// and records a last-fragment flag per slave AW in the B-response tracking FIFO.
// Define CAXI4_DWC_AWSPLIT_ERR_EN to add the sticky split_err output (pop while FIFO empty).
module caxi4interconnect_dwc_aw_splitter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int ID_WIDTH         = 1,
    parameter int USER_WIDTH       = 1,
    parameter int MASTER_SIZE_LOG2 = 4,
    parameter int SLAVE_SIZE_LOG2  = 2,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                  ACLK,
    input  logic                  sysReset,
    input  logic [ID_WIDTH-1:0]   MASTER_AWID,
    input  logic [ADDR_WIDTH-1:0] MASTER_AWADDR,
    input  logic [7:0]            MASTER_AWLEN,
    input  logic [1:0]            MASTER_AWBURST,
    input  logic [USER_WIDTH-1:0] MASTER_AWUSER,
    input  logic                  MASTER_AWVALID,
    output logic                  MASTER_AWREADY,
    output logic [ID_WIDTH-1:0]   SLAVE_AWID,
    output logic [ADDR_WIDTH-1:0] SLAVE_AWADDR,
    output logic [7:0]            SLAVE_AWLEN,
    output logic [2:0]            SLAVE_AWSIZE,
    output logic [1:0]            SLAVE_AWBURST,
    output logic [USER_WIDTH-1:0] SLAVE_AWUSER,
    output logic                  SLAVE_AWVALID,
    input  logic                  SLAVE_AWREADY,
    input  logic                  brespFifore,
    output logic                  BRespFifoRdData,
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
    output logic                  split_err,
`endif
    output logic                  bresp_fifo_empty
);

    localparam int R     = MASTER_SIZE_LOG2 - SLAVE_SIZE_LOG2;
    localparam int CW    = 9 + R;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q;
    logic                    awready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic [2:0]              size_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic [CW-1:0]           rem_q;

    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic                       mem_q [DEPTH];

    logic [CW-1:0]         startRem_d, nextRem_d, fragBeats;
    logic [7:0]            startLen_d, nextLen_d;
    logic [ADDR_WIDTH-1:0] nextAddr_d;
    logic                  fifoFull, slaveHs, lastFrag, fifoPush, fifoPop;

    function automatic logic [7:0] fragLen(input logic [CW-1:0] rem);
        if (rem > CW'(256)) return 8'd255;
        return 8'(rem - CW'(1));
    endfunction

    // FIXED/WRAP look like a single-fragment INCR: remaining = AWLEN+1 so the first AW is also the last.
    always_comb begin
        startRem_d = CW'({1'b0, MASTER_AWLEN} + 9'd1);
        if (MASTER_AWBURST == 2'b01)
            startRem_d = (CW'({1'b0, MASTER_AWLEN} + 9'd1) << R)
                         - CW'(MASTER_AWADDR[MASTER_SIZE_LOG2-1:SLAVE_SIZE_LOG2]);
        startLen_d = fragLen(startRem_d);
        fragBeats  = CW'({1'b0, len_q} + 9'd1);
        nextRem_d  = rem_q - fragBeats;
        nextLen_d  = fragLen(nextRem_d);
        nextAddr_d = (addr_q & ({ADDR_WIDTH{1'b1}} << SLAVE_SIZE_LOG2))
                     + (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << SLAVE_SIZE_LOG2);
    end

    assign fifoFull = (count_q == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign slaveHs  = SLAVE_AWVALID && SLAVE_AWREADY;
    assign lastFrag = (rem_q == fragBeats);
    assign fifoPush = slaveHs;
    assign fifoPop  = brespFifore && (count_q != '0);

    assign MASTER_AWREADY   = awready_q;
    assign SLAVE_AWVALID    = (state_q == ISSUE) && !fifoFull;
    assign SLAVE_AWID       = id_q;
    assign SLAVE_AWADDR     = addr_q;
    assign SLAVE_AWLEN      = len_q;
    assign SLAVE_AWSIZE     = size_q;
    assign SLAVE_AWBURST    = burst_q;
    assign SLAVE_AWUSER     = user_q;
    assign bresp_fifo_empty = (count_q == '0);
    assign BRespFifoRdData  = bresp_fifo_empty ? 1'b0 : mem_q[rptr_q];

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            state_q   <= IDLE;
            awready_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            size_q    <= '0;
            id_q      <= '0;
            user_q    <= '0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MASTER_AWVALID && awready_q) begin
                        state_q   <= ISSUE;
                        awready_q <= 1'b0;
                        addr_q    <= MASTER_AWADDR;
                        len_q     <= startLen_d;
                        burst_q   <= MASTER_AWBURST;
                        size_q    <= 3'(SLAVE_SIZE_LOG2);
                        id_q      <= MASTER_AWID;
                        user_q    <= MASTER_AWUSER;
                        rem_q     <= startRem_d;
                    end
                end
                ISSUE: begin
                    if (slaveHs) begin
                        if (lastFrag) begin
                            state_q   <= IDLE;
                            awready_q <= 1'b1;
                        end else begin
                            rem_q  <= nextRem_d;
                            addr_q <= nextAddr_d;
                            len_q  <= nextLen_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (fifoPush) wptr_q <= wptr_q + 1'b1;
            if (fifoPop)  rptr_q <= rptr_q + 1'b1;
            case ({fifoPush, fifoPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge ACLK) begin
        if (fifoPush) mem_q[wptr_q] <= lastFrag;
    end

`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
    logic splitErr_q;
    assign split_err = splitErr_q;

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset)
            splitErr_q <= 1'b0;
        else if (brespFifore && bresp_fifo_empty)
            splitErr_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_caxi4interconnect_dwc_aw_splitter.sv
// Scoreboard bench for the DWC AW splitter: directed commands push expected slave AWs and FIFO flags,
// a negedge monitor pops and compares them; FIFO depth is 4 so the full-FIFO stall is reachable.
module tb_caxi4interconnect_dwc_aw_splitter;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic        id;
        logic        user;
    } aw_t;

    logic        ACLK = 1'b0;
    logic        sysReset;
    logic        MASTER_AWID;
    logic [31:0] MASTER_AWADDR;
    logic [7:0]  MASTER_AWLEN;
    logic [1:0]  MASTER_AWBURST;
    logic        MASTER_AWUSER;
    logic        MASTER_AWVALID;
    logic        MASTER_AWREADY;
    logic        SLAVE_AWID;
    logic [31:0] SLAVE_AWADDR;
    logic [7:0]  SLAVE_AWLEN;
    logic [2:0]  SLAVE_AWSIZE;
    logic [1:0]  SLAVE_AWBURST;
    logic        SLAVE_AWUSER;
    logic        SLAVE_AWVALID;
    logic        SLAVE_AWREADY;
    logic        brespFifore;
    logic        BRespFifoRdData;
    logic        bresp_fifo_empty;
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
    logic        split_err;
`endif

    aw_t  expAwQ[$];
    logic expFlagQ[$];
    aw_t  monAw;
    int   checks = 0;
    int   errors = 0;

    caxi4interconnect_dwc_aw_splitter #(
        .ADDR_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1),
        .MASTER_SIZE_LOG2(4), .SLAVE_SIZE_LOG2(2), .FIFO_DEPTH_LOG2(2)
    ) dut (
        .ACLK(ACLK), .sysReset(sysReset),
        .MASTER_AWID(MASTER_AWID), .MASTER_AWADDR(MASTER_AWADDR), .MASTER_AWLEN(MASTER_AWLEN),
        .MASTER_AWBURST(MASTER_AWBURST), .MASTER_AWUSER(MASTER_AWUSER),
        .MASTER_AWVALID(MASTER_AWVALID), .MASTER_AWREADY(MASTER_AWREADY),
        .SLAVE_AWID(SLAVE_AWID), .SLAVE_AWADDR(SLAVE_AWADDR), .SLAVE_AWLEN(SLAVE_AWLEN),
        .SLAVE_AWSIZE(SLAVE_AWSIZE), .SLAVE_AWBURST(SLAVE_AWBURST), .SLAVE_AWUSER(SLAVE_AWUSER),
        .SLAVE_AWVALID(SLAVE_AWVALID), .SLAVE_AWREADY(SLAVE_AWREADY),
        .brespFifore(brespFifore), .BRespFifoRdData(BRespFifoRdData),
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
        .split_err(split_err),
`endif
        .bresp_fifo_empty(bresp_fifo_empty)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic expectAw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic user, input logic flag);
        expAwQ.push_back('{addr: addr, len: len, burst: burst, size: 3'd2, id: id, user: user});
        expFlagQ.push_back(flag);
    endtask

    // Returns one cycle after the edge on which the master command was accepted.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                                 input logic id, input logic user);
        bit accepted = 0;
        MASTER_AWADDR  = addr;
        MASTER_AWLEN   = len;
        MASTER_AWBURST = burst;
        MASTER_AWID    = id;
        MASTER_AWUSER  = user;
        MASTER_AWVALID = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            if (MASTER_AWREADY) accepted = 1;
            tick();
        end
        MASTER_AWVALID = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL master accept timeout: got MASTER_AWREADY=0, expected 1");
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!MASTER_AWREADY && n < 600) begin
            tick();
            n++;
        end
        checkOutput("return to idle", 64'(MASTER_AWREADY), 64'd1);
    endtask

    task automatic popFifo(input int n);
        brespFifore = 1'b1;
        repeat (n) tick();
        brespFifore = 1'b0;
    endtask

    always @(negedge ACLK) begin
        if (sysReset && SLAVE_AWVALID && SLAVE_AWREADY) begin
            monAw = '{addr: SLAVE_AWADDR, len: SLAVE_AWLEN, burst: SLAVE_AWBURST,
                      size: SLAVE_AWSIZE, id: SLAVE_AWID, user: SLAVE_AWUSER};
            if (expAwQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected slave AW: got 0x%0h, expected none", monAw);
            end else begin
                checkOutput("slave AW", 64'(monAw), 64'(expAwQ.pop_front()));
            end
        end
        if (sysReset && brespFifore && !bresp_fifo_empty) begin
            if (expFlagQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected FIFO entry: got %0b, expected none", BRespFifoRdData);
            end else begin
                checkOutput("FIFO flag", 64'(BRespFifoRdData), 64'(expFlagQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sysReset = 1'b0; MASTER_AWID = 1'b0; MASTER_AWADDR = '0; MASTER_AWLEN = '0;
        MASTER_AWBURST = INCR; MASTER_AWUSER = 1'b0; MASTER_AWVALID = 1'b0;
        SLAVE_AWREADY = 1'b0; brespFifore = 1'b0;
        repeat (3) tick();
        checkOutput("reset MASTER_AWREADY", 64'(MASTER_AWREADY), 64'd1);
        checkOutput("reset SLAVE_AWVALID", 64'(SLAVE_AWVALID), 64'd0);
        checkOutput("reset SLAVE_AW fields", {SLAVE_AWADDR, SLAVE_AWLEN, SLAVE_AWSIZE, SLAVE_AWBURST,
                    SLAVE_AWID, SLAVE_AWUSER}, 64'd0);
        checkOutput("reset FIFO empty/data", {bresp_fifo_empty, BRespFifoRdData}, 64'b10);
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
        checkOutput("reset split_err", 64'(split_err), 64'd0);
`endif
        sysReset = 1'b1;
        SLAVE_AWREADY = 1'b1;
        tick();

        // 400 beats from 0x1000: 256 + 144
        expectAw(32'h1000, 8'd255, INCR, 1'b1, 1'b0, 1'b0);
        expectAw(32'h1400, 8'd143, INCR, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h1000, 8'd99, INCR, 1'b1, 1'b0);
        checkOutput("400b AWREADY low after accept", 64'(MASTER_AWREADY), 64'd0);
        checkOutput("400b SLAVE_AWVALID", 64'(SLAVE_AWVALID), 64'd1);
        tick();
        checkOutput("400b AWREADY low between fragments", 64'(MASTER_AWREADY), 64'd0);
        tick();
        checkOutput("400b AWREADY after last handshake", 64'(MASTER_AWREADY), 64'd1);
        checkOutput("400b SLAVE_AWVALID idle", 64'(SLAVE_AWVALID), 64'd0);
        popFifo(2);
        checkOutput("400b FIFO drained", 64'(bresp_fifo_empty), 64'd1);

        // Offset 2 within the master word leaves 2 slave beats
        expectAw(32'h1008, 8'd1, INCR, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h1008, 8'd0, INCR, 1'b0, 1'b1);
        waitIdle();
        popFifo(1);
        checkOutput("offset FIFO drained", 64'(bresp_fifo_empty), 64'd1);

        // 1024 beats: four back-to-back full fragments, filling the depth-4 FIFO
        expectAw(32'h000, 8'd255, INCR, 1'b0, 1'b0, 1'b0);
        expectAw(32'h400, 8'd255, INCR, 1'b0, 1'b0, 1'b0);
        expectAw(32'h800, 8'd255, INCR, 1'b0, 1'b0, 1'b0);
        expectAw(32'hC00, 8'd255, INCR, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 8'd255, INCR, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("1024b AWREADY before 4th handshake", 64'(MASTER_AWREADY), 64'd0);
        tick();
        checkOutput("1024b AWREADY after 4th handshake", 64'(MASTER_AWREADY), 64'd1);
        checkOutput("1024b FIFO not empty", 64'(bresp_fifo_empty), 64'd0);

        // FIFO full: next command is accepted but held until one pop frees a slot
        expectAw(32'h2000, 8'd15, INCR, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'h2000, 8'd3, INCR, 1'b1, 1'b1);
        checkOutput("full SLAVE_AWVALID gated", 64'(SLAVE_AWVALID), 64'd0);
        repeat (3) tick();
        checkOutput("full stall persists", {MASTER_AWREADY, SLAVE_AWVALID}, 64'b00);
        popFifo(1);
        checkOutput("full SLAVE_AWVALID after pop", 64'(SLAVE_AWVALID), 64'd1);
        tick();
        checkOutput("full AWREADY after push", 64'(MASTER_AWREADY), 64'd1);
        popFifo(4);
        checkOutput("full FIFO drained", 64'(bresp_fifo_empty), 64'd1);

        // WRAP forwarded as a single fragment; then push and pop together at count 1
        expectAw(32'h3000, 8'd3, WRAP, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h3000, 8'd3, WRAP, 1'b0, 1'b0);
        waitIdle();
        expectAw(32'h3040, 8'd3, WRAP, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h3040, 8'd3, WRAP, 1'b1, 1'b0);
        popFifo(1);
        checkOutput("push+pop keeps count 1", 64'(bresp_fifo_empty), 64'd0);
        popFifo(1);
        checkOutput("push+pop then single pop empties", 64'(bresp_fifo_empty), 64'd1);

        // Pop while empty is ignored
        popFifo(1);
        checkOutput("pop while empty", {bresp_fifo_empty, BRespFifoRdData}, 64'b10);
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
        checkOutput("split_err set", 64'(split_err), 64'd1);
        repeat (2) tick();
        checkOutput("split_err sticky", 64'(split_err), 64'd1);
`endif
        expectAw(32'h4000, 8'd3, FIXED, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h4000, 8'd3, FIXED, 1'b0, 1'b1);
        waitIdle();
        popFifo(1);
        checkOutput("FIXED FIFO drained", 64'(bresp_fifo_empty), 64'd1);

        // Reset during the second fragment of the 400-beat burst
        expectAw(32'h1000, 8'd255, INCR, 1'b0, 1'b0, 1'b0);
        expectAw(32'h1400, 8'd143, INCR, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h1000, 8'd99, INCR, 1'b0, 1'b0);
        tick();
        checkOutput("second fragment address", 64'(SLAVE_AWADDR), 64'h1400);
        SLAVE_AWREADY = 1'b0;
        sysReset = 1'b0;
        #1;
        checkOutput("mid-burst reset outputs", {SLAVE_AWVALID, bresp_fifo_empty, MASTER_AWREADY}, 64'b011);
        tick();
        sysReset = 1'b1;
        expAwQ.delete();
        expFlagQ.delete();
        SLAVE_AWREADY = 1'b1;
        tick();
`ifdef CAXI4_DWC_AWSPLIT_ERR_EN
        checkOutput("split_err cleared by reset", 64'(split_err), 64'd0);
`endif
        expectAw(32'h1008, 8'd1, INCR, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'h1008, 8'd0, INCR, 1'b1, 1'b1);
        waitIdle();
        popFifo(1);
        checkOutput("post-reset FIFO drained", 64'(bresp_fifo_empty), 64'd1);

        tick();
        checkOutput("expected AWs all seen", 64'(expAwQ.size()), 64'd0);
        checkOutput("expected flags all seen", 64'(expFlagQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
